// File: rtl/gbt_tx_ctrl.sv
// gbt_tx_ctrl: GBTx uplink transmit controller.
// Brings the link up, then arbitrates DAQ/slow-control frames.
//
// Ports:
//   CLK, RSTN      frame clock, sync active-low reset
//   GBT_RDY, EN    GBTx ready, transmit enable
//   DAQ_*          DAQ frame request (DATA/VLD) and ACK
//   SC_*           slow-control frame request and ACK
//   GBT_TXD/TXVD   registered frame word and data-valid
//   TX_SRC         registered source: 0 idle, 1 DAQ, 2 SC
//   STATE          0 OFF, 1 SYNC, 2 RUN
//   FRM_CNT        data frames sent, wraps at 2^16
//   LINK_ERR       sticky: GBT_RDY lost in RUN
module gbt_tx_ctrl #(
  parameter int DW = 80,
  parameter int SYNC_FRAMES = 16,
  parameter int MAX_DAQ = 8,
  parameter logic [DW-1:0] IDLE_WORD = {DW{1'b0}}
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          GBT_RDY,
  input  logic          EN,
  input  logic [DW-1:0] DAQ_DATA,
  input  logic          DAQ_VLD,
  output logic          DAQ_ACK,
  input  logic [DW-1:0] SC_DATA,
  input  logic          SC_VLD,
  output logic          SC_ACK,
  output logic [DW-1:0] GBT_TXD,
  output logic          GBT_TXVD,
  output logic [1:0]    TX_SRC,
  output logic [1:0]    STATE,
  output logic [15:0]   FRM_CNT,
  output logic          LINK_ERR
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_SYNC = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam logic [7:0] SYNC_LAST = 8'(SYNC_FRAMES - 1);
  localparam logic [7:0] MAX_RUN   = 8'(MAX_DAQ);

  state_e        state_q, state_d;
  logic [7:0]    sync_cnt_q, sync_cnt_d;
  logic [7:0]    daq_run_q, daq_run_d;
  logic [DW-1:0] txd_q, txd_d;
  logic          txvd_q, txvd_d;
  logic [1:0]    src_q, src_d;
  logic [15:0]   frm_cnt_q, frm_cnt_d;
  logic          link_err_q, link_err_d;

  logic link_ok;
  logic run_ok;
  logic daq_gnt;
  logic sc_gnt;

  // RSTN gates the ACKs so nothing is accepted in a reset cycle.
  assign link_ok = GBT_RDY & EN;
  assign run_ok  = (state_q == ST_RUN) & link_ok & RSTN;

  // DAQ wins unless SC is waiting and DAQ used its run budget.
  assign daq_gnt = run_ok & DAQ_VLD
                 & (~SC_VLD | (daq_run_q < MAX_RUN));
  assign sc_gnt  = run_ok & SC_VLD & ~daq_gnt;

  assign DAQ_ACK  = daq_gnt;
  assign SC_ACK   = sc_gnt;
  assign GBT_TXD  = txd_q;
  assign GBT_TXVD = txvd_q;
  assign TX_SRC   = src_q;
  assign STATE    = state_q;
  assign FRM_CNT  = frm_cnt_q;
  assign LINK_ERR = link_err_q;

  always_comb begin
    state_d    = state_q;
    sync_cnt_d = sync_cnt_q;
    link_err_d = link_err_q;
    unique case (state_q)
      ST_OFF: begin
        if (link_ok) state_d = ST_SYNC;
      end
      ST_SYNC: begin
        if (!link_ok) begin
          state_d    = ST_OFF;
          sync_cnt_d = '0;
        end else if (sync_cnt_q == SYNC_LAST) begin
          state_d    = ST_RUN;
          sync_cnt_d = '0;
        end else begin
          sync_cnt_d = sync_cnt_q + 8'd1;
        end
      end
      ST_RUN: begin
        if (!GBT_RDY) begin
          state_d    = ST_OFF;
          link_err_d = 1'b1;
        end else if (!EN) begin
          state_d = ST_OFF;
        end
      end
      default: state_d = ST_OFF;
    endcase
  end

  always_comb begin
    txd_d     = IDLE_WORD;
    txvd_d    = 1'b0;
    src_d     = 2'd0;
    frm_cnt_d = frm_cnt_q;
    daq_run_d = '0;
    if (daq_gnt) begin
      txd_d     = DAQ_DATA;
      txvd_d    = 1'b1;
      src_d     = 2'd1;
      frm_cnt_d = frm_cnt_q + 16'd1;
      daq_run_d = (daq_run_q < MAX_RUN) ?
                  daq_run_q + 8'd1 : daq_run_q;
    end else if (sc_gnt) begin
      txd_d     = SC_DATA;
      txvd_d    = 1'b1;
      src_d     = 2'd2;
      frm_cnt_d = frm_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q    <= ST_OFF;
      sync_cnt_q <= '0;
      daq_run_q  <= '0;
      txd_q      <= IDLE_WORD;
      txvd_q     <= 1'b0;
      src_q      <= 2'd0;
      frm_cnt_q  <= '0;
      link_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_cnt_q <= sync_cnt_d;
      daq_run_q  <= daq_run_d;
      txd_q      <= txd_d;
      txvd_q     <= txvd_d;
      src_q      <= src_d;
      frm_cnt_q  <= frm_cnt_d;
      link_err_q <= link_err_d;
    end
  end

endmodule

// File: tb/tb_gbt_tx_ctrl.sv
// tb_gbt_tx_ctrl: directed bench for gbt_tx_ctrl.
// Link-up, DAQ stream, contention, SC yield, wrap, link loss.
module tb_gbt_tx_ctrl;

  localparam int DW = 80;

  logic          CLK = 1'b0;
  logic          RSTN;
  logic          GBT_RDY;
  logic          EN;
  logic [DW-1:0] DAQ_DATA;
  logic          DAQ_VLD;
  logic          DAQ_ACK;
  logic [DW-1:0] SC_DATA;
  logic          SC_VLD;
  logic          SC_ACK;
  logic [DW-1:0] GBT_TXD;
  logic          GBT_TXVD;
  logic [1:0]    TX_SRC;
  logic [1:0]    STATE;
  logic [15:0]   FRM_CNT;
  logic          LINK_ERR;

  int checks = 0;
  int errors = 0;
  int m;

  gbt_tx_ctrl dut (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .GBT_RDY  (GBT_RDY),
    .EN       (EN),
    .DAQ_DATA (DAQ_DATA),
    .DAQ_VLD  (DAQ_VLD),
    .DAQ_ACK  (DAQ_ACK),
    .SC_DATA  (SC_DATA),
    .SC_VLD   (SC_VLD),
    .SC_ACK   (SC_ACK),
    .GBT_TXD  (GBT_TXD),
    .GBT_TXVD (GBT_TXVD),
    .TX_SRC   (TX_SRC),
    .STATE    (STATE),
    .FRM_CNT  (FRM_CNT),
    .LINK_ERR (LINK_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic sync_seq(input logic err);
    tick();
    chk("sync_enter", STATE, 2'd1);
    chk("sync_txvd", GBT_TXVD, 1'b0);
    for (int i = 0; i < 15; i++) begin
      #1;
      chk("sync_st", STATE, 2'd1);
      chk("sync_ack", DAQ_ACK | SC_ACK, 1'b0);
      chk("sync_err", LINK_ERR, err);
      tick();
    end
    chk("sync_pre_run", STATE, 2'd1);
    tick();
    chk("run_enter", STATE, 2'd2);
  endtask

  initial begin
    RSTN     = 1'b0;
    GBT_RDY  = 1'b0;
    EN       = 1'b0;
    DAQ_DATA = '0;
    DAQ_VLD  = 1'b0;
    SC_DATA  = '0;
    SC_VLD   = 1'b0;
    tick();
    tick();
    chk("rst_state", STATE, 2'd0);
    chk("rst_txvd", GBT_TXVD, 1'b0);
    chk("rst_txd", GBT_TXD, '0);
    chk("rst_src", TX_SRC, 2'd0);
    chk("rst_frm", FRM_CNT, 16'd0);
    chk("rst_err", LINK_ERR, 1'b0);
    chk("rst_ack", DAQ_ACK | SC_ACK, 1'b0);

    // link-up with requests pending: no ACK before RUN
    RSTN    = 1'b1;
    GBT_RDY = 1'b1;
    EN      = 1'b1;
    DAQ_VLD = 1'b1;
    SC_VLD  = 1'b1;
    #1;
    chk("off_ack", DAQ_ACK | SC_ACK, 1'b0);
    sync_seq(1'b0);
    DAQ_VLD = 1'b0;
    SC_VLD  = 1'b0;
    #1;
    chk("run_idle_ack", DAQ_ACK | SC_ACK, 1'b0);
    chk("run_txvd0", GBT_TXVD, 1'b0);

    // DAQ only: 10 words, output one cycle behind
    for (int i = 0; i < 10; i++) begin
      DAQ_DATA = 80'h1000 + 80'(i);
      DAQ_VLD  = 1'b1;
      #1;
      chk("daq_ack", DAQ_ACK, 1'b1);
      if (i > 0) begin
        chk("daq_txvd", GBT_TXVD, 1'b1);
        chk("daq_txd", GBT_TXD, 80'h1000 + 80'(i - 1));
        chk("daq_src", TX_SRC, 2'd1);
      end
      tick();
    end
    DAQ_VLD = 1'b0;
    #1;
    chk("daq_last_txd", GBT_TXD, 80'h1009);
    chk("daq_last_vd", GBT_TXVD, 1'b1);
    chk("daq_frm", FRM_CNT, 16'd10);
    tick();
    chk("daq_end_vd", GBT_TXVD, 1'b0);
    chk("daq_end_txd", GBT_TXD, '0);
    chk("daq_end_src", TX_SRC, 2'd0);

    // contention: 8 DAQ then 1 SC, twice
    DAQ_DATA = 80'hAAAA;
    SC_DATA  = 80'h5555;
    DAQ_VLD  = 1'b1;
    SC_VLD   = 1'b1;
    for (int k = 0; k < 18; k++) begin
      #1;
      chk("cont_dack", DAQ_ACK, (k % 9) != 8);
      chk("cont_sack", SC_ACK, (k % 9) == 8);
      tick();
      chk("cont_src", TX_SRC,
          ((k % 9) == 8) ? 2'd2 : 2'd1);
      chk("cont_vd", GBT_TXVD, 1'b1);
    end
    chk("cont_frm", FRM_CNT, 16'd28);

    // SC only, then DAQ joins and wins at once
    DAQ_VLD = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("sc_ack", SC_ACK, 1'b1);
      tick();
      chk("sc_src", TX_SRC, 2'd2);
      chk("sc_txd", GBT_TXD, 80'h5555);
    end
    DAQ_VLD = 1'b1;
    #1;
    chk("yield_dack", DAQ_ACK, 1'b1);
    chk("yield_sack", SC_ACK, 1'b0);
    tick();
    chk("yield_src", TX_SRC, 2'd1);
    chk("yield_txd", GBT_TXD, 80'hAAAA);
    chk("yield_frm", FRM_CNT, 16'd32);
    SC_VLD = 1'b0;

    // stream DAQ to 0xFFFE, then watch the wrap
    m = 32;
    while (m != 16'hFFFE) begin
      tick();
      m++;
    end
    chk("pre_wrap", FRM_CNT, 16'hFFFE);
    tick();
    chk("wrap_ffff", FRM_CNT, 16'hFFFF);
    tick();
    chk("wrap_0000", FRM_CNT, 16'h0000);
    tick();
    chk("wrap_0001", FRM_CNT, 16'h0001);

    // drop EN in RUN: OFF, no link error
    DAQ_VLD = 1'b0;
    EN      = 1'b0;
    #1;
    chk("en_ack", DAQ_ACK, 1'b0);
    tick();
    chk("en_state", STATE, 2'd0);
    chk("en_err", LINK_ERR, 1'b0);
    chk("en_vd", GBT_TXVD, 1'b0);
    EN = 1'b1;
    sync_seq(1'b0);

    // link loss with DAQ pending
    DAQ_VLD = 1'b1;
    #1;
    chk("loss_ack_pre", DAQ_ACK, 1'b1);
    GBT_RDY = 1'b0;
    #1;
    chk("loss_ack", DAQ_ACK, 1'b0);
    tick();
    chk("loss_state", STATE, 2'd0);
    chk("loss_vd", GBT_TXVD, 1'b0);
    chk("loss_err", LINK_ERR, 1'b1);
    chk("loss_frm", FRM_CNT, 16'h0001);
    GBT_RDY = 1'b1;
    sync_seq(1'b1);
    chk("relink_err", LINK_ERR, 1'b1);

    // reset mid-stream: ACK suppressed, all cleared
    #1;
    chk("rr_ack_pre", DAQ_ACK, 1'b1);
    RSTN = 1'b0;
    #1;
    chk("rr_ack", DAQ_ACK, 1'b0);
    tick();
    chk("rr_state", STATE, 2'd0);
    chk("rr_err", LINK_ERR, 1'b0);
    chk("rr_frm", FRM_CNT, 16'd0);
    chk("rr_vd", GBT_TXVD, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gbt_tx_ctrl.md
# gbt_tx_ctrl

Transmit-side controller for the GBTx uplink. It brings the link from idle into data mode after the GBTx reports ready. It then arbitrates each 40 MHz frame slot between the DAQ stream and the slow-control stream. It drives the frame word and the TX-valid pin (GBT_TXVD); GBT_TXVD feeds the output buffer, which today is tied low.

## Interface
Parameters:
- DW, 80, frame payload width in bits.
- SYNC_FRAMES, 16, number of idle frames sent after link-up before entering data mode; range 1–255.
- MAX_DAQ, 8, maximum consecutive DAQ grants while slow control is pending; range 1–255.
- IDLE_WORD, {DW{1'b0}}, payload driven whenever no data frame is sent.

Ports:
- CLK  in  1  frame clock (40 MHz); all logic on rising edge.
- RSTN  in  1  synchronous, active-low reset.
- GBT_RDY  in  1  GBTx TX-ready/locked.
- EN  in  1  transmit enable from configuration.
- DAQ_DATA  in  DW  DAQ frame payload.
- DAQ_VLD  in  1  DAQ frame available.
- DAQ_ACK  out  1  DAQ frame accepted this cycle (combinational).
- SC_DATA  in  DW  slow-control frame payload.
- SC_VLD  in  1  slow-control frame available.
- SC_ACK  out  1  slow-control frame accepted this cycle (combinational).
- GBT_TXD  out  DW  frame word to the GBTx (registered).
- GBT_TXVD  out  1  data-frame valid to the GBTx (registered).
- TX_SRC  out  2  source of the current GBT_TXD: 0 idle, 1 DAQ, 2 SC (registered).
- STATE  out  2  0 OFF, 1 SYNC, 2 RUN.
- FRM_CNT  out  16  count of data frames sent; wraps modulo 2^16.
- LINK_ERR  out  1  sticky flag: GBT_RDY was lost while in RUN.

## Operation
- States:
  - OFF → SYNC when GBT_RDY & EN.
  - SYNC → RUN after SYNC_FRAMES consecutive SYNC cycles, i.e. when the sync counter equals SYNC_FRAMES-1 with GBT_RDY & EN still high.
  - SYNC → OFF if !GBT_RDY or !EN. The sync counter clears on every exit from SYNC.
  - RUN → OFF on !GBT_RDY; this also sets LINK_ERR.
  - RUN → OFF on !EN; LINK_ERR unchanged.
  - If both drop together, LINK_ERR is set.
- Handshake: a frame transfers when VLD & ACK in the same cycle. Requesters hold DATA/VLD stable until ACK. ACK is asserted only when STATE=RUN & GBT_RDY & EN, and at most one ACK is high per cycle.
- Arbitration in RUN, with daq_run = consecutive DAQ grants, saturating at MAX_DAQ:
  - Grant DAQ if DAQ_VLD & (!SC_VLD | daq_run < MAX_DAQ).
  - Otherwise grant SC if SC_VLD.
  - Otherwise grant nothing.
  - A DAQ grant increments daq_run. An SC grant or an empty slot clears it.
- Output register, loaded every cycle:
  - On a grant: GBT_TXD = granted DATA, GBT_TXVD = 1, TX_SRC = source, and FRM_CNT increments.
  - With no grant: GBT_TXD = IDLE_WORD, GBT_TXVD = 0, TX_SRC = 0.
- FRM_CNT wraps 0xFFFF → 0x0000 without a flag.
- LINK_ERR clears only on reset.
- A reset mid-operation takes effect at the next edge regardless of pending handshakes. An ACK in the reset cycle is not honoured.

## Timing
- Reset (RSTN low at an edge) sets:
  - STATE = OFF, sync counter = 0, daq_run = 0.
  - GBT_TXD = IDLE_WORD, GBT_TXVD = 0, TX_SRC = 0.
  - FRM_CNT = 0, LINK_ERR = 0.
  - DAQ_ACK and SC_ACK are therefore 0 during reset and after it.
- Accept-to-output latency is 1 cycle: data accepted in cycle n appears on GBT_TXD/GBT_TXVD in cycle n+1.
- Throughput is one frame per cycle, with no bubbles between back-to-back grants.
- Link-up: with GBT_RDY & EN high from cycle 0 in OFF:
  - STATE = SYNC at cycle 1.
  - STATE = RUN at cycle 1+SYNC_FRAMES.
  - The first possible ACK is at cycle 1+SYNC_FRAMES.
  - The first GBT_TXVD is at cycle 2+SYNC_FRAMES.
- Loss of GBT_RDY in RUN:
  - ACK drops in the same cycle.
  - The next edge sets STATE = OFF, GBT_TXVD = 0 and LINK_ERR = 1.

## Test plan
- Link-up (defaults): reset, then GBT_RDY = EN = 1 → STATE 0 → 1 at the first edge and 1 → 2 exactly 16 edges later. GBT_TXVD stays 0 throughout. Both ACKs stay 0 until RUN.
- DAQ only: DAQ_VLD held for 10 incrementing words → 10 DAQ_ACKs. GBT_TXVD is high for exactly 10 cycles, one cycle behind the ACKs, with words in order and TX_SRC = 1. FRM_CNT = 10 afterwards.
- Contention: DAQ_VLD and SC_VLD both held, MAX_DAQ = 8 → the grant pattern repeats 8×DAQ then 1×SC. TX_SRC sequence is 1,1,1,1,1,1,1,1,2, repeated, with no idle gap.
- SC priority yield: SC_VLD only → SC_ACK every cycle. Adding DAQ_VLD mid-stream → DAQ granted on the next cycle.
- Link loss: in RUN with DAQ_VLD high, drop GBT_RDY → DAQ_ACK goes 0 in the same cycle. Next cycle: STATE = 0, GBT_TXVD = 0, LINK_ERR = 1. Restoring GBT_RDY → a full 16-cycle SYNC before RUN, and LINK_ERR stays 1 until RSTN.
- Counter wrap: preload FRM_CNT to 0xFFFE with 3 accepted frames → it reads 0xFFFF, then 0x0000, then 0x0001. Then drop EN in RUN → STATE = 0 with LINK_ERR unchanged.
